xfer_reg_fifo: RTL and testbench

- Parametrised successor to the team's two-register staging/transfer block.
- A single request port writes data words into a DEPTH-entry staging FIFO. A transfer command pops the FIFO head into the output register that drives dout.
- Adds a registered ack/err handshake, status and control registers, sticky overflow/underflow flags, and a flush.
- Sits between the testbench/bus driver and downstream logic that consumes dout.

---
 rtl/xfer_reg_pkg.sv | 59 +++++
 rtl/xfer_reg_fifo_sync_fifo.sv | 57 +++++
 rtl/xfer_reg_fifo.sv | 151 +++++++++++++++
 tb/tb_xfer_reg_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/xfer_reg_pkg.sv
// Shared constants for the register-mapped transfer FIFO block:
// register addresses, STATUS/CTRL bit positions and the request decoder.
package xfer_reg_pkg;

   localparam int ADDR_DATA   = 0;
   localparam int ADDR_STATUS = 1;
   localparam int ADDR_CTRL   = 2;
   localparam int ADDR_OUT    = 3;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_UDF     = 3;
   localparam int ST_CNT_LSB = 4;

   localparam int CTRL_FLUSH = 0;
   localparam int CTRL_CLR   = 1;

   // Bit positions in the ADDR_CTRL read-back word.
   localparam int FLAG_UDF = 0;
   localparam int FLAG_OVF = 1;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_PUSH,
      OP_XFER,
      OP_STATUS,
      OP_CTRL_WR,
      OP_CTRL_RD,
      OP_OUT_RD,
      OP_BAD
   } op_e;

   // Anything not listed (writes to STATUS/OUT, out-of-range
   // addresses) falls into OP_BAD.
   function automatic op_e decode_op(
      input logic        req,
      input logic        wr,
      input int unsigned a
   );
      op_e op;
      op = OP_BAD;
      if (!req) begin
         op = OP_NONE;
      end else begin
         unique case (1'b1)
            (a == ADDR_DATA)   &&  wr: op = OP_PUSH;
            (a == ADDR_DATA)   && !wr: op = OP_XFER;
            (a == ADDR_STATUS) && !wr: op = OP_STATUS;
            (a == ADDR_CTRL)   &&  wr: op = OP_CTRL_WR;
            (a == ADDR_CTRL)   && !wr: op = OP_CTRL_RD;
            (a == ADDR_OUT)    && !wr: op = OP_OUT_RD;
            default:                   op = OP_BAD;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/xfer_reg_fifo_sync_fifo.sv
// xfer_sync_fifo: DEPTH-entry synchronous staging FIFO with flush.
// Ports: clk, rst (sync, active-high), push, pop, flush, din,
//        dout_head (current head word), count, full, empty.
module xfer_sync_fifo #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout_head,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic              do_push;
   logic              do_pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign dout_head = mem[rptr];

   // Pointers are power-of-two wide, so they wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_W'(1);
         if (do_pop)  rptr <= rptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; stale words are unreachable once the
   // pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) mem[wptr] <= din;
   end

endmodule

// File: rtl/xfer_reg_fifo.sv
// xfer_reg_fifo: register-mapped staging FIFO feeding a transfer register.
// Ports: clk, rst (sync, active-high), req/wr/addr/din request port,
//        rdata/ack/err response (ack one cycle after the op edge),
//        dout transfer register, full/empty FIFO status.
module xfer_reg_fifo
   import xfer_reg_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 4,
   parameter  int ADDR_W = 2,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              err,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   op_e               op;
   logic              push;
   logic              pop;
   logic              flush;
   logic              clr;
   logic              set_ovf;
   logic              set_udf;
   logic              ovf;
   logic              udf;
   logic [DATA_W-1:0] head;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] status;
   logic [DATA_W-1:0] rdata_d;
   logic              err_d;

   // First response stage, captured on the op edge.
   logic              s1_ack;
   logic              s1_err;
   logic [DATA_W-1:0] s1_rdata;

   xfer_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .din       (din),
      .dout_head (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Snapshot of state before this cycle's update.
   always_comb begin
      status                     = '0;
      status[ST_EMPTY]           = empty;
      status[ST_FULL]            = full;
      status[ST_OVF]             = ovf;
      status[ST_UDF]             = udf;
      status[ST_CNT_LSB +: CNT_W] = count;
   end

   always_comb begin
      op      = decode_op(req, wr, 32'(addr));
      push    = 1'b0;
      pop     = 1'b0;
      flush   = 1'b0;
      clr     = 1'b0;
      set_ovf = 1'b0;
      set_udf = 1'b0;
      rdata_d = '0;
      err_d   = 1'b0;
      unique case (op)
         OP_PUSH: begin
            if (full) begin
               err_d   = 1'b1;
               set_ovf = 1'b1;
            end else begin
               push = 1'b1;
            end
         end
         OP_XFER: begin
            if (empty) begin
               err_d   = 1'b1;
               set_udf = 1'b1;
            end else begin
               pop     = 1'b1;
               rdata_d = head;
            end
         end
         OP_STATUS: rdata_d = status;
         OP_CTRL_WR: begin
            flush = din[CTRL_FLUSH];
            clr   = din[CTRL_CLR];
         end
         OP_CTRL_RD: begin
            rdata_d[FLAG_OVF] = ovf;
            rdata_d[FLAG_UDF] = udf;
         end
         OP_OUT_RD: rdata_d = dout;
         OP_BAD:    err_d   = 1'b1;
         default:   err_d   = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
         ovf  <= 1'b0;
         udf  <= 1'b0;
      end else begin
         if (pop) dout <= head;
         if (clr) begin
            ovf <= 1'b0;
            udf <= 1'b0;
         end
         if (set_ovf) ovf <= 1'b1;
         if (set_udf) udf <= 1'b1;
      end
   end

   // Two-stage response pipe: ack lands the cycle after the op edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_ack   <= 1'b0;
         s1_err   <= 1'b0;
         s1_rdata <= '0;
         ack      <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
      end else begin
         s1_ack   <= req;
         s1_err   <= err_d;
         s1_rdata <= rdata_d;
         ack      <= s1_ack;
         err      <= s1_err;
         rdata    <= s1_rdata;
      end
   end

endmodule

// File: tb/tb_xfer_reg_fifo.sv
// Scoreboard bench for xfer_reg_fifo (DATA_W=8, DEPTH=4, ADDR_W=2).
// Stimulus pushes expected responses; a monitor checks each ack.
module tb_xfer_reg_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic       wr  = 1'b0;
   logic [1:0] addr = '0;
   logic [7:0] din  = '0;
   logic [7:0] rdata;
   logic       ack;
   logic       err;
   logic [7:0] dout;
   logic       full;
   logic       empty;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] rd;
      logic       er;
      bit         crd;
      bit         cdo;
      logic [7:0] dv;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   xfer_reg_fifo #(
      .DATA_W (8),
      .DEPTH  (4),
      .ADDR_W (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .wr    (wr),
      .addr  (addr),
      .din   (din),
      .rdata (rdata),
      .ack   (ack),
      .err   (err),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
                  nm, act, expv, $time);
      end
   endtask

   // Drive one request for one cycle (no deassert).
   task automatic op(input logic w, input logic [1:0] a,
                     input logic [7:0] d, input logic [7:0] erd,
                     input logic eerr, input bit crd, input bit cdo,
                     input logic [7:0] edo);
      exp_t e;
      @(negedge clk);
      e.rd  = erd;
      e.er  = eerr;
      e.crd = crd;
      e.cdo = cdo;
      e.dv  = edo;
      q.push_back(e);
      req  = 1'b1;
      wr   = w;
      addr = a;
      din  = d;
   endtask

   task automatic gap();
      @(negedge clk);
      req = 1'b0;
   endtask

   // Single spaced request: dout is stable when its ack arrives.
   task automatic sop(input logic w, input logic [1:0] a,
                      input logic [7:0] d, input logic [7:0] erd,
                      input logic eerr, input bit crd, input bit cdo,
                      input logic [7:0] edo);
      op(w, a, d, erd, eerr, crd, cdo, edo);
      gap();
   endtask

   task automatic wpush(input logic [7:0] d, input logic eerr);
      sop(1'b1, 2'd0, d, 8'h00, eerr, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic rd(input logic [1:0] a, input logic [7:0] erd,
                     input logic eerr);
      sop(1'b0, a, 8'h00, erd, eerr, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic xfer(input logic [7:0] erd, input logic eerr,
                       input logic [7:0] edo);
      sop(1'b0, 2'd0, 8'h00, erd, eerr, 1'b1, 1'b1, edo);
   endtask

   task automatic ctrl(input logic [7:0] d);
      sop(1'b1, 2'd2, d, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Monitor: every ack must match the oldest expected response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ack === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
               e = q.pop_front();
               chk("err", 32'(err), 32'(e.er));
               if (e.crd) chk("rdata", 32'(rdata), 32'(e.rd));
               if (e.cdo) chk("dout", 32'(dout), 32'(e.dv));
            end
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);

      rd(2'd1, 8'h01, 1'b0);
      sop(1'b0, 2'd1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 8'h00);

      wpush(8'hA5, 1'b0);
      wpush(8'h3C, 1'b0);
      chk("two_empty", 32'(empty), 32'd0);
      xfer(8'hA5, 1'b0, 8'hA5);
      xfer(8'h3C, 1'b0, 8'h3C);
      chk("drained_empty", 32'(empty), 32'd1);

      // Back-to-back pushes, fifth overflows.
      op(1'b1, 2'd0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      op(1'b1, 2'd0, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      op(1'b1, 2'd0, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      op(1'b1, 2'd0, 8'h44, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      op(1'b1, 2'd0, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
      gap();
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_empty", 32'(empty), 32'd0);
      rd(2'd1, 8'h46, 1'b0);
      xfer(8'h11, 1'b0, 8'h11);
      xfer(8'h22, 1'b0, 8'h22);
      xfer(8'h33, 1'b0, 8'h33);
      xfer(8'h44, 1'b0, 8'h44);
      chk("ovf_drained", 32'(empty), 32'd1);

      rd(2'd2, 8'h02, 1'b0);
      ctrl(8'h02);
      xfer(8'h00, 1'b1, 8'h44);
      rd(2'd2, 8'h01, 1'b0);
      rd(2'd1, 8'h09, 1'b0);
      ctrl(8'h02);
      rd(2'd2, 8'h00, 1'b0);

      wpush(8'h01, 1'b0);
      wpush(8'h02, 1'b0);
      wpush(8'h03, 1'b0);
      xfer(8'h01, 1'b0, 8'h01);
      xfer(8'h02, 1'b0, 8'h02);
      wpush(8'h04, 1'b0);
      wpush(8'h05, 1'b0);
      wpush(8'h06, 1'b0);
      chk("wrap_full", 32'(full), 32'd1);
      ctrl(8'h01);
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_dout", 32'(dout), 32'h02);
      rd(2'd1, 8'h01, 1'b0);
      rd(2'd3, 8'h02, 1'b0);
      wpush(8'h77, 1'b0);
      xfer(8'h77, 1'b0, 8'h77);

      sop(1'b1, 2'd3, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77);
      sop(1'b1, 2'd1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77);
      rd(2'd3, 8'h77, 1'b0);
      rd(2'd1, 8'h01, 1'b0);

      // Reset in the same cycle as a push: no ack, nothing stored.
      repeat (3) @(negedge clk);
      rst  = 1'b1;
      req  = 1'b1;
      wr   = 1'b1;
      addr = 2'd0;
      din  = 8'h99;
      @(negedge clk);
      rst = 1'b0;
      req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstmid_empty", 32'(empty), 32'd1);
      chk("rstmid_dout", 32'(dout), 32'd0);
      rd(2'd1, 8'h01, 1'b0);
      rd(2'd3, 8'h00, 1'b0);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      chk("drain_pending", 32'(q.size()), 32'd0);
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
